// File: rtl/sdram_arbiter_if.sv
// Request/response bundle between the three requesters, the arbiter and the sdram controller.
interface sdram_arbiter_if;
  logic        p0_req, p0_we, p0_ack;
  logic [24:0] p0_addr;
  logic [7:0]  p0_din, p0_dout;
  logic        p1_req, p1_we, p1_ack;
  logic [24:0] p1_addr;
  logic [7:0]  p1_din, p1_dout;
  logic        p2_req, p2_we, p2_ack;
  logic [24:0] p2_addr;
  logic [7:0]  p2_din, p2_dout;
  logic        mem_cs, mem_we, mem_refresh, mem_ready;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_din,
    input  p1_req, p1_we, p1_addr, p1_din,
    input  p2_req, p2_we, p2_addr, p2_din,
    output p0_dout, p0_ack, p1_dout, p1_ack, p2_dout, p2_ack,
    output mem_cs, mem_we, mem_addr, mem_din, mem_refresh,
    input  mem_dout, mem_ready
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_din,
    output p1_req, p1_we, p1_addr, p1_din,
    output p2_req, p2_we, p2_addr, p2_din,
    input  p0_dout, p0_ack, p1_dout, p1_ack, p2_dout, p2_ack,
    input  mem_cs, mem_we, mem_addr, mem_din, mem_refresh,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-port + refresh slot arbiter in front of the sdram controller.
// Every access occupies one fixed SLOT_LEN-clock slot; all outputs registered.
module sdram_arbiter_port (
  input  logic       clk,
  input  logic       reset,
  input  logic       cap,
  input  logic       ack_nxt,
  input  logic [7:0] mem_dout,
  output logic [7:0] dout,
  output logic       ack
);
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= ack_nxt;
      if (cap) dout <= mem_dout;
    end
  end
endmodule

module sdram_arbiter #(
  parameter int SLOT_LEN         = 8,
  parameter int REFRESH_INTERVAL = 499
) (
  input  logic           clk,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);
  localparam int SW = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1;
  localparam int TW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SLOT_LEN - 1);
  localparam logic [SW-1:0] S_CAP  = SW'(SLOT_LEN - 2);
  localparam logic [TW-1:0] T_LAST = TW'(REFRESH_INTERVAL - 1);

  typedef enum logic       {ST_IDLE, ST_SLOT} state_t;
  typedef enum logic [1:0] {K_REF, K_P0, K_P1, K_P2} kind_t;

  function automatic logic [2:0] port_sel(input kind_t k);
    case (k)
      K_P0:    return 3'b001;
      K_P1:    return 3'b010;
      K_P2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0]       req, we, elig, cap, ack_nxt, ack;
  logic [2:0][24:0] addr;
  logic [2:0][7:0]  din, dout;

  assign req  = {bus.p2_req,  bus.p1_req,  bus.p0_req};
  assign we   = {bus.p2_we,   bus.p1_we,   bus.p0_we};
  assign addr = {bus.p2_addr, bus.p1_addr, bus.p0_addr};
  assign din  = {bus.p2_din,  bus.p1_din,  bus.p0_din};

  state_t          state, nstate;
  kind_t           kind, nkind, gkind;
  logic [SW-1:0]   s, ns;
  logic [TW-1:0]   tmr;
  logic [1:0]      ref_pending, pend_nxt, gidx;
  logic            rr, last, decide, grant, wrap;
  logic            mem_cs_q, mem_we_q, mem_ref_q;
  logic [24:0]     mem_addr_q;
  logic [7:0]      mem_din_q;

  always_comb begin
    last   = (state == ST_SLOT) && (s == S_LAST);
    decide = (state == ST_IDLE) || last;
    // The port being acked still holds req during its ack clock; keep it out of the re-grant.
    elig   = req & ~({3{last}} & port_sel(kind));
    grant  = 1'b0;
    gkind  = K_REF;
    if (decide && bus.mem_ready) begin
      grant = 1'b1;
      if (ref_pending != 2'd0)           gkind = K_REF;
      else if (elig[0])                  gkind = K_P0;
      else if (elig[1] && !(elig[2] && rr)) gkind = K_P1;
      else if (elig[2])                  gkind = K_P2;
      else                               grant = 1'b0;
    end
    case (gkind)
      K_P1:    gidx = 2'd1;
      K_P2:    gidx = 2'd2;
      default: gidx = 2'd0;
    endcase

    nstate = state;
    nkind  = kind;
    ns     = s + 1'b1;
    if (grant) begin
      nstate = ST_SLOT;
      nkind  = gkind;
      ns     = '0;
    end else if (decide) begin
      nstate = ST_IDLE;
      ns     = '0;
    end

    wrap     = (tmr == T_LAST);
    pend_nxt = ref_pending - {1'b0, (grant && gkind == K_REF)};
    if (wrap && pend_nxt != 2'd3) pend_nxt = pend_nxt + 2'd1;

    cap     = {3{(state == ST_SLOT) && (s == S_CAP) && !mem_we_q}} & port_sel(kind);
    ack_nxt = {3{(nstate == ST_SLOT) && (ns == S_LAST)}} & port_sel(nkind);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      kind        <= K_REF;
      s           <= '0;
      tmr         <= '0;
      ref_pending <= '0;
      rr          <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_ref_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state       <= nstate;
      kind        <= nkind;
      s           <= ns;
      tmr         <= wrap ? '0 : tmr + 1'b1;
      ref_pending <= pend_nxt;
      if (grant && gkind == K_P1)      rr <= 1'b1;
      else if (grant && gkind == K_P2) rr <= 1'b0;
      if (grant && gkind != K_REF) begin
        mem_we_q   <= we[gidx];
        mem_addr_q <= addr[gidx];
        mem_din_q  <= din[gidx];
      end
      // Strobes drop in the last slot clock so the next slot always sees a fresh rising edge.
      mem_cs_q  <= (nstate == ST_SLOT) && (nkind != K_REF) && (ns != S_LAST);
      mem_ref_q <= (nstate == ST_SLOT) && (nkind == K_REF) && (ns != S_LAST);
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_port
    sdram_arbiter_port u_port (
      .clk      (clk),
      .reset    (reset),
      .cap      (cap[i]),
      .ack_nxt  (ack_nxt[i]),
      .mem_dout (bus.mem_dout),
      .dout     (dout[i]),
      .ack      (ack[i])
    );
  end

  assign bus.p0_dout     = dout[0];
  assign bus.p1_dout     = dout[1];
  assign bus.p2_dout     = dout[2];
  assign bus.p0_ack      = ack[0];
  assign bus.p1_ack      = ack[1];
  assign bus.p2_ack      = ack[2];
  assign bus.mem_cs      = mem_cs_q;
  assign bus.mem_refresh = mem_ref_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench: requesters and an sdram read-data model drive the arbiter; every slot is checked on completion.
module tb_sdram_arbiter;
  localparam int RI = 499;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0, c0 = 0, n_chk = 0, n_fail = 0, extras = 0, prev_start = 0;

  sdram_arbiter_if bus();
  sdram_arbiter #(.SLOT_LEN(8), .REFRESH_INTERVAL(RI)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {logic we; logic [24:0] addr; logic [7:0] din;} req_t;
  typedef struct {int kind; logic we; logic [24:0] addr; logic [7:0] din; logic [7:0] dout; int gap; int lat;} exp_t;

  req_t             pq[3][$];
  exp_t             expq[$];
  logic [2:0]       req_v, we_v, ack_seen, acks;
  logic [2:0][24:0] addr_v;
  logic [2:0][7:0]  din_v, douts;
  int               req_cyc[3];
  logic             ready_v;

  assign bus.p0_req = req_v[0];  assign bus.p1_req = req_v[1];  assign bus.p2_req = req_v[2];
  assign bus.p0_we  = we_v[0];   assign bus.p1_we  = we_v[1];   assign bus.p2_we  = we_v[2];
  assign bus.p0_addr = addr_v[0]; assign bus.p1_addr = addr_v[1]; assign bus.p2_addr = addr_v[2];
  assign bus.p0_din = din_v[0];  assign bus.p1_din = din_v[1];  assign bus.p2_din = din_v[2];
  assign bus.mem_ready = ready_v;
  assign acks  = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
  assign douts = {bus.p2_dout, bus.p1_dout, bus.p0_dout};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rdata(input logic [24:0] a);
    return a[7:0] ^ 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cs"},   bus.mem_cs, 0);
    chk({tag, "_ref"},  bus.mem_refresh, 0);
    chk({tag, "_we"},   bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_din"},  bus.mem_din, 0);
    chk({tag, "_ack"},  acks, 0);
    chk({tag, "_dout"}, douts, 0);
  endtask

  task automatic do_reset(input bit zchk);
    tick(); reset = 1'b1;
    tick(); if (zchk) check_zero("rst");
    tick(); reset = 1'b0;
    c0 = cyc;
  endtask

  task automatic push_req(input int p, input logic we, input logic [24:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.din = d;
    pq[p].push_back(r);
  endtask

  task automatic push_exp(input int k, input logic we, input logic [24:0] a, input logic [7:0] d,
                          input int gap, input int lat);
    exp_t e;
    e.kind = k; e.we = we; e.addr = a; e.din = d; e.dout = rdata(a); e.gap = gap; e.lat = lat;
    expq.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk({tag, "_drain"}, expq.size(), 0);
    repeat (12) @(posedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic handle(input int kind, input logic we, input logic [24:0] a, input logic [7:0] d,
                        input logic [7:0] q, input int start);
    exp_t e;
    if (expq.size() == 0) begin
      extras++;
      chk("extra_slot", extras, 0);
    end else begin
      e = expq.pop_front();
      chk("slot_kind", kind, e.kind);
      if (e.kind < 3 && kind == e.kind) begin
        chk("mem_addr", a, e.addr);
        chk("mem_we", we, e.we);
        if (e.we) chk("mem_din", d, e.din);
        else      chk("rd_dout", q, e.dout);
        if (e.lat != 0) chk("req_ack_lat", cyc - req_cyc[kind], e.lat);
      end
      if (e.gap != 0) chk("slot_gap", start - prev_start, e.gap);
    end
    prev_start = start;
  endtask

  // sdram model: read data only valid at s=5..6 of a port slot
  int   scnt = 0;
  logic cs_seen = 1'b0;
  initial begin
    bus.mem_dout = 8'hEE;
    forever begin
      tick();
      scnt    = (bus.mem_cs && cs_seen) ? scnt + 1 : 0;
      cs_seen = bus.mem_cs;
      bus.mem_dout = (bus.mem_cs && scnt >= 5) ? rdata(bus.mem_addr) : 8'hEE;
    end
  end

  // Requesters: hold req through the ack clock, then drop or move to the next queued access.
  initial begin
    req_t r;
    req_v = '0; we_v = '0; addr_v = '0; din_v = '0; ack_seen = '0;
    forever begin
      @(posedge clk); #2;
      for (int p = 0; p < 3; p++) begin
        if (req_v[p] && acks[p]) ack_seen[p] = 1'b1;
        else if (ack_seen[p]) begin ack_seen[p] = 1'b0; req_v[p] = 1'b0; end
        if (!req_v[p] && !ack_seen[p] && pq[p].size() != 0) begin
          r = pq[p].pop_front();
          we_v[p] = r.we; addr_v[p] = r.addr; din_v[p] = r.din;
          req_v[p] = 1'b1; req_cyc[p] = cyc;
        end
      end
    end
  end

  // Slot monitor
  logic        cs_q = 1'b0, rf_q = 1'b0, aborted = 1'b0, unstable, cs_in_rf, c_we;
  logic [2:0]  ack_q = '0;
  logic [24:0] c_addr;
  logic [7:0]  c_din;
  int          cs_len, rf_len, cur_start;
  initial forever begin
    @(negedge clk);
    if (reset) aborted = 1'b1;
    if (bus.mem_cs && !cs_q) begin
      cur_start = cyc; cs_len = 0; unstable = 1'b0; aborted = 1'b0;
      c_we = bus.mem_we; c_addr = bus.mem_addr; c_din = bus.mem_din;
    end
    if (bus.mem_cs) begin
      cs_len++;
      if (bus.mem_we !== c_we || bus.mem_addr !== c_addr || bus.mem_din !== c_din) unstable = 1'b1;
    end
    if (!bus.mem_cs && cs_q && !aborted) begin
      chk("cs_len", cs_len, 7);
      chk("mem_stable", unstable, 0);
    end
    if (bus.mem_refresh && !rf_q) begin cur_start = cyc; rf_len = 0; cs_in_rf = 1'b0; aborted = 1'b0; end
    if (bus.mem_refresh) begin rf_len++; if (bus.mem_cs) cs_in_rf = 1'b1; end
    if (!bus.mem_refresh && rf_q && !aborted) begin
      chk("ref_len", rf_len, 7);
      chk("ref_cs", cs_in_rf, 0);
      handle(3, 1'b0, '0, '0, '0, cur_start);
    end
    for (int p = 0; p < 3; p++)
      if (acks[p]) begin
        chk("ack_pulse", ack_q[p], 0);
        handle(p, c_we, c_addr, c_din, douts[p], cur_start);
      end
    cs_q = bus.mem_cs; rf_q = bus.mem_refresh; ack_q = acks;
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    int n;
    ready_v = 1'b1;
    do_reset(1'b1);

    // single P0 read
    push_req(0, 1'b0, 25'h000005A, 8'h00);
    push_exp(0, 1'b0, 25'h000005A, 8'h00, 0, 8);
    drain("t1", 40);
    chk("t1_dout", bus.p0_dout, 8'hA5);

    // P0 write, req held through the ack clock
    do_reset(1'b0);
    push_req(0, 1'b1, 25'h1ABCDEF, 8'h3C);
    push_exp(0, 1'b1, 25'h1ABCDEF, 8'h3C, 0, 8);
    drain("t5", 40);
    chk("t5_dout_hold", bus.p0_dout, 8'h00);

    // P1/P2 round robin
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      push_req(1, 1'b1, 25'h0000100 + 25'(i), 8'h10 + 8'(i));
      push_req(2, 1'b0, 25'h1000020 + 25'(3 * i), 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 1'b1, 25'h0000100 + 25'(i), 8'h10 + 8'(i), (i == 0) ? 0 : 8, 0);
      push_exp(2, 1'b0, 25'h1000020 + 25'(3 * i), 8'h00, 8, 0);
    end
    drain("t2", 100);

    // reset at s=3 of a P2 read
    do_reset(1'b0);
    push_req(2, 1'b0, 25'h0F0F0F0, 8'h00);
    push_exp(2, 1'b0, 25'h0F0F0F0, 8'h00, 0, 0);
    n = 0;
    while (!bus.mem_cs && n < 20) begin tick(); n++; end
    chk("t6_grant", bus.mem_cs, 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_zero("mid_rst");
    reset = 1'b0;
    drain("t6", 40);

    // refresh wrap while all ports request
    do_reset(1'b0);
    wait_until(c0 + RI - 4);
    push_req(0, 1'b0, 25'h0000111, 8'h00);
    push_req(0, 1'b1, 25'h0000222, 8'h77);
    push_req(1, 1'b0, 25'h0000333, 8'h00);
    push_req(2, 1'b1, 25'h0000444, 8'h99);
    push_exp(0, 1'b0, 25'h0000111, 8'h00, 0, 0);
    push_exp(3, 1'b0, 25'h0, 8'h00, 8, 0);
    push_exp(0, 1'b1, 25'h0000222, 8'h77, 8, 0);
    push_exp(1, 1'b0, 25'h0000333, 8'h00, 8, 0);
    push_exp(2, 1'b1, 25'h0000444, 8'h99, 8, 0);
    drain("t3", 100);

    // refresh backlog saturates at 3 while mem_ready is low
    ready_v = 1'b0;
    do_reset(1'b0);
    push_req(1, 1'b0, 25'h0000555, 8'h00);
    push_exp(3, 1'b0, 25'h0, 8'h00, 0, 0);
    push_exp(3, 1'b0, 25'h0, 8'h00, 8, 0);
    push_exp(3, 1'b0, 25'h0, 8'h00, 8, 0);
    push_exp(1, 1'b0, 25'h0000555, 8'h00, 8, 0);
    wait_until(c0 + 4 * RI + 5);
    chk("t4_blocked", expq.size(), 4);
    ready_v = 1'b1;
    drain("t4", 80);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
